systolic_skew_feeder: RTL and testbench
=======================================

SYSTOLIC_SKEW_FEEDER -- requirements
Module: systolic_skew_feeder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 12, giving the element width of both operand matrices.
REQ-002 SHALL have the array dimension fixed at N=4: 4x4 A (data) matrix and 4x4 B (weight) matrix.
REQ-003 SHALL use one clock, clk; reset is rst, asynchronous and active-low.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst  input  1  asynchronous active-low reset.
REQ-006 load_en  input  1  write strobe for operand storage.
REQ-007 load_sel  input  1  0 = write A, 1 = write B.
REQ-008 load_addr  input  4  element index, row*4+col.
REQ-009 load_data  input  DATA_WIDTH  element value.
REQ-010 start  input  1  single-cycle request to stream the stored matrices.
REQ-011 out_ready  input  1  downstream can accept a beat (driven from ~fifo_full of the array's input FIFOs).
REQ-012 data_r1..data_r4  output  DATA_WIDTH each  skewed A row streams, one per array row.
REQ-013 weight_c1..weight_c4  output  DATA_WIDTH each  skewed B column streams, one per array column.
REQ-014 out_valid  output  1  beat present; used as the array FIFO write enable.
REQ-015 busy  output  1  high in STREAM and DONE.
REQ-016 done  output  1  one-cycle pulse after the last beat is accepted.

Function
REQ-017 SHALL implement FSM states IDLE, STREAM, DONE, plus a 3-bit beat counter t (0..6).
REQ-018 IDLE: load_en=1 SHALL write load_data into A[addr] or B[addr] at the clock edge; start=1 SHALL move to STREAM with t=0.
REQ-019 load_en and start asserted on the same IDLE edge SHALL both take effect; the first beat SHALL reflect the newly written element.
REQ-020 load_en in STREAM or DONE SHALL be ignored, leaving storage unchanged; start outside IDLE SHALL be ignored.
REQ-021 STREAM: out_valid SHALL be 1; a beat is accepted on any edge with out_valid=1 and out_ready=1.
REQ-022 Beat t SHALL drive data_r(i+1) = A[i][t-i] if 0 <= t-i <= 3, else 0, for i = 0..3.
REQ-023 Beat t SHALL drive weight_c(j+1) = B[t-j][j] if 0 <= t-j <= 3, else 0, for j = 0..3.
REQ-024 out_ready=0 SHALL hold t and keep all outputs stable (no advance, no drop, no duplication).
REQ-025 An accepted beat with t<6 SHALL increment t; an accepted beat with t=6 SHALL move to DONE.
REQ-026 Exactly 7 beats SHALL be accepted per start (2N-1).
REQ-027 Latency: start sampled at edge k SHALL give out_valid=1 in the cycle after edge k.
REQ-028 DONE SHALL last exactly one cycle with done=1, out_valid=0, then return to IDLE; done SHALL NOT depend on out_ready.
REQ-029 Whenever out_valid=0, all data_r*/weight_c* outputs SHALL be 0.
REQ-030 Values SHALL pass through unmodified; no arithmetic or width change.
REQ-031 Stored matrices SHALL persist across runs, so a second start replays the same stream without reloading.

Reset
REQ-032 rst=0 SHALL immediately force state IDLE, t=0, out_valid=0, busy=0, done=0, and all data_r*/weight_c*=0.
REQ-033 rst=0 SHALL clear all A and B elements to 0.
REQ-034 rst asserted mid-STREAM SHALL abort the run with no done pulse; after release the block SHALL wait in IDLE for a new start.

Verification
REQ-035 Load A[r][c]=4r+c+1 and B[r][c]=16+4r+c+1, start, out_ready=1 -> beat 0: data_r1=1, weight_c1=17, others 0; beat 3: data_r1..r4=4,7,10,13 and weight_c1..c4=29,26,23,20; beat 6: data_r4=16, weight_c4=32, others 0; done pulses the cycle after beat 6.
REQ-036 Same load; hold out_ready=0 for 3 cycles during beat 2 -> outputs frozen at beat-2 values (data_r1..r3=3,6,9); exactly 7 beats accepted in total; done follows the final acceptance.
REQ-037 Pulse start during STREAM and load_en during STREAM writing A[0]=99 -> run unaffected; next run beat 0 data_r1=1.
REQ-038 Assert rst at beat 4 -> outputs 0 at once, no done; after release, start -> all beats 0 (matrices cleared).
REQ-039 load_en (A[0]=5) and start on the same IDLE edge -> beat 0 data_r1=5.
REQ-040 Two back-to-back runs without reload -> identical 7-beat sequences.

Source files
------------

// File: rtl/systolic_skew_feeder.sv
// ============================================================================
// Module      : systolic_skew_feeder
// Description : Holds a 4x4 data matrix and a 4x4 weight matrix and streams
//               them into a systolic array as diagonally skewed row/column
//               beats under ready/valid flow control.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module systolic_skew_feeder #(
  parameter int DATA_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_en,
  input  logic                  load_sel,
  input  logic [3:0]            load_addr,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  start,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] data_r1,
  output logic [DATA_WIDTH-1:0] data_r2,
  output logic [DATA_WIDTH-1:0] data_r3,
  output logic [DATA_WIDTH-1:0] data_r4,
  output logic [DATA_WIDTH-1:0] weight_c1,
  output logic [DATA_WIDTH-1:0] weight_c2,
  output logic [DATA_WIDTH-1:0] weight_c3,
  output logic [DATA_WIDTH-1:0] weight_c4,
  output logic                  out_valid,
  output logic                  busy,
  output logic                  done
);

  localparam int         c_N         = 4;
  localparam int         c_ELEMS     = c_N * c_N;
  localparam logic [2:0] c_LAST_BEAT = 3'd6;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t                r_state;
  logic [2:0]            r_t;
  logic                  r_out_valid;
  logic                  r_busy;
  logic                  r_done;
  logic [DATA_WIDTH-1:0] r_a [c_ELEMS];
  logic [DATA_WIDTH-1:0] r_b [c_ELEMS];
  logic [DATA_WIDTH-1:0] w_row [c_N];
  logic [DATA_WIDTH-1:0] w_col [c_N];

  // Operand storage is writable only while idle, so a running stream never
  // observes a partially updated matrix.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < c_ELEMS; k++) begin
        r_a[k] <= '0;
        r_b[k] <= '0;
      end
    end else if (r_state == S_IDLE && load_en) begin
      if (load_sel) r_b[load_addr] <= load_data;
      else          r_a[load_addr] <= load_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_t         <= 3'd0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_t <= 3'd0;
          if (start) begin
            r_state     <= S_STREAM;
            r_out_valid <= 1'b1;
            r_busy      <= 1'b1;
          end
        end
        S_STREAM: begin
          if (out_ready) begin
            if (r_t == c_LAST_BEAT) begin
              r_state     <= S_DONE;
              r_out_valid <= 1'b0;
              r_done      <= 1'b1;
            end else begin
              r_t <= r_t + 3'd1;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_t     <= 3'd0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
        default: begin
          r_state     <= S_IDLE;
          r_t         <= 3'd0;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_done      <= 1'b0;
        end
      endcase
    end
  end

  // Lane k carries element (t-k) of its row/column; outside the 0..3 window
  // the lane is idle and driven to zero.
  for (genvar k = 0; k < c_N; k++) begin : g_lane
    localparam logic [2:0] c_LANE = 3'(k);
    localparam logic [1:0] c_IDX  = 2'(k);
    logic [2:0] w_off;
    logic       w_in;
    assign w_off    = r_t - c_LANE;
    assign w_in     = (r_t >= c_LANE) && (w_off <= 3'd3);
    assign w_row[k] = (r_out_valid && w_in) ? r_a[{c_IDX, w_off[1:0]}] : '0;
    assign w_col[k] = (r_out_valid && w_in) ? r_b[{w_off[1:0], c_IDX}] : '0;
  end

  assign data_r1   = w_row[0];
  assign data_r2   = w_row[1];
  assign data_r3   = w_row[2];
  assign data_r4   = w_row[3];
  assign weight_c1 = w_col[0];
  assign weight_c2 = w_col[1];
  assign weight_c3 = w_col[2];
  assign weight_c4 = w_col[3];
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

`default_nettype wire

// File: tb/tb_systolic_skew_feeder.sv
// ============================================================================
// Module      : tb_systolic_skew_feeder
// Description : Directed self-checking bench for systolic_skew_feeder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_systolic_skew_feeder;

  localparam int DATA_WIDTH = 12;

  logic                  clk;
  logic                  rst;
  logic                  load_en;
  logic                  load_sel;
  logic [3:0]            load_addr;
  logic [DATA_WIDTH-1:0] load_data;
  logic                  start;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] d1, d2, d3, d4, w1, w2, w3, w4;
  logic                  out_valid, busy, done;

  logic [DATA_WIDTH-1:0] dv [4];
  logic [DATA_WIDTH-1:0] wv [4];
  logic [DATA_WIDTH-1:0] ma [16];
  logic [DATA_WIDTH-1:0] mb [16];
  logic [DATA_WIDTH-1:0] cap_d [7][4];
  logic [DATA_WIDTH-1:0] cap_w [7][4];
  logic [DATA_WIDTH-1:0] stall_d [4];

  int n_vec;
  int n_err;

  systolic_skew_feeder #(.DATA_WIDTH(DATA_WIDTH)) dut (
    .clk(clk), .rst(rst),
    .load_en(load_en), .load_sel(load_sel), .load_addr(load_addr), .load_data(load_data),
    .start(start), .out_ready(out_ready),
    .data_r1(d1), .data_r2(d2), .data_r3(d3), .data_r4(d4),
    .weight_c1(w1), .weight_c2(w2), .weight_c3(w3), .weight_c4(w4),
    .out_valid(out_valid), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    dv[0] = d1; dv[1] = d2; dv[2] = d3; dv[3] = d4;
    wv[0] = w1; wv[1] = w2; wv[2] = w3; wv[3] = w4;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [DATA_WIDTH-1:0] exp_d(input int i, input int t);
    if (t >= i && t - i <= 3) return ma[i*4 + (t - i)];
    return '0;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] exp_w(input int j, input int t);
    if (t >= j && t - j <= 3) return mb[(t - j)*4 + j];
    return '0;
  endfunction

  function automatic logic all_zero();
    logic z = 1'b1;
    for (int k = 0; k < 4; k++) if (dv[k] != 0 || wv[k] != 0) z = 1'b0;
    return z;
  endfunction

  task automatic load(input logic sel, input int addr, input logic [DATA_WIDTH-1:0] v);
    @(negedge clk);
    load_en = 1'b1; load_sel = sel; load_addr = 4'(addr); load_data = v;
    if (sel) mb[addr] = v; else ma[addr] = v;
  endtask

  task automatic kick(input logic ld, input logic [DATA_WIDTH-1:0] v);
    @(negedge clk);
    start = 1'b1; out_ready = 1'b1;
    load_en = ld; load_sel = 1'b0; load_addr = 4'd0; load_data = v;
    if (ld) ma[0] = v;
  endtask

  // Drives one stream to completion, checking every displayed beat against
  // the model, then checks the done pulse and the return to idle.
  task automatic stream(input int stall_beat, input int stall_n, input int inject_beat);
    int  bc = 0;
    int  stalls = 0;
    int  cyc = 0;
    while (bc < 7 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      start = 1'b0; load_en = 1'b0;
      check_val("out_valid", {31'd0, out_valid}, 1);
      check_val("busy", {31'd0, busy}, 1);
      for (int k = 0; k < 4; k++) begin
        check_val($sformatf("data_r%0d@%0d", k+1, bc), 32'(dv[k]), 32'(exp_d(k, bc)));
        check_val($sformatf("weight_c%0d@%0d", k+1, bc), 32'(wv[k]), 32'(exp_w(k, bc)));
      end
      if (bc == stall_beat && stalls < stall_n) begin
        out_ready = 1'b0;
        stalls++;
        for (int k = 0; k < 4; k++) stall_d[k] = dv[k];
      end else begin
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
          cap_d[bc][k] = dv[k];
          cap_w[bc][k] = wv[k];
        end
        if (bc == inject_beat) begin
          start = 1'b1; load_en = 1'b1; load_sel = 1'b0; load_addr = 4'd0; load_data = 99;
        end
        bc++;
      end
    end
    check_val("beats_accepted", 32'(bc), 7);
    @(negedge clk);
    start = 1'b0; load_en = 1'b0; out_ready = 1'b0;
    check_val("done_pulse", {31'd0, done}, 1);
    check_val("done_valid", {31'd0, out_valid}, 0);
    check_val("done_busy", {31'd0, busy}, 1);
    check_val("done_zero", {31'd0, all_zero()}, 1);
    @(negedge clk);
    out_ready = 1'b1;
    check_val("idle_done", {31'd0, done}, 0);
    check_val("idle_busy", {31'd0, busy}, 0);
    check_val("idle_valid", {31'd0, out_valid}, 0);
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    rst = 1'b0; load_en = 1'b0; load_sel = 1'b0; load_addr = '0; load_data = '0;
    start = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin ma[k] = '0; mb[k] = '0; end

    #2;
    check_val("rst_valid", {31'd0, out_valid}, 0);
    check_val("rst_busy", {31'd0, busy}, 0);
    check_val("rst_done", {31'd0, done}, 0);
    check_val("rst_outs", {31'd0, all_zero()}, 1);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    for (int k = 0; k < 16; k++) load(1'b0, k, DATA_WIDTH'(k + 1));
    for (int k = 0; k < 16; k++) load(1'b1, k, DATA_WIDTH'(k + 17));

    // Basic run with hand-computed beats 0, 3 and 6.
    kick(1'b0, '0);
    stream(-1, 0, -1);
    check_val("b0_r1", 32'(cap_d[0][0]), 1);
    check_val("b0_c1", 32'(cap_w[0][0]), 17);
    check_val("b0_r2", 32'(cap_d[0][1]), 0);
    check_val("b3_r1", 32'(cap_d[3][0]), 4);
    check_val("b3_r2", 32'(cap_d[3][1]), 7);
    check_val("b3_r3", 32'(cap_d[3][2]), 10);
    check_val("b3_r4", 32'(cap_d[3][3]), 13);
    check_val("b3_c1", 32'(cap_w[3][0]), 29);
    check_val("b3_c2", 32'(cap_w[3][1]), 26);
    check_val("b3_c3", 32'(cap_w[3][2]), 23);
    check_val("b3_c4", 32'(cap_w[3][3]), 20);
    check_val("b6_r4", 32'(cap_d[6][3]), 16);
    check_val("b6_c4", 32'(cap_w[6][3]), 32);
    check_val("b6_r3", 32'(cap_d[6][2]), 0);

    // Back-pressure held for three cycles on beat 2.
    kick(1'b0, '0);
    stream(2, 3, -1);
    check_val("stall_r1", 32'(stall_d[0]), 3);
    check_val("stall_r2", 32'(stall_d[1]), 6);
    check_val("stall_r3", 32'(stall_d[2]), 9);

    // start and a write to A[0] during a run must both be ignored.
    kick(1'b0, '0);
    stream(-1, 0, 3);
    kick(1'b0, '0);
    stream(-1, 0, -1);
    check_val("replay_b0_r1", 32'(cap_d[0][0]), 1);

    // Reset asserted while beat 4 is displayed.
    kick(1'b0, '0);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check_val("b4_r2", 32'(d2), 8);
    check_val("b4_c2", 32'(w2), 30);
    #2 rst = 1'b0;
    #1;
    check_val("mid_rst_valid", {31'd0, out_valid}, 0);
    check_val("mid_rst_outs", {31'd0, all_zero()}, 1);
    check_val("mid_rst_busy", {31'd0, busy}, 0);
    repeat (2) begin
      @(negedge clk);
      check_val("mid_rst_done", {31'd0, done}, 0);
    end
    rst = 1'b1;
    for (int k = 0; k < 16; k++) begin ma[k] = '0; mb[k] = '0; end
    repeat (3) begin
      @(negedge clk);
      check_val("post_rst_done", {31'd0, done}, 0);
      check_val("post_rst_valid", {31'd0, out_valid}, 0);
    end
    kick(1'b0, '0);
    stream(-1, 0, -1);

    // Same-edge load and start: first beat shows the new element.
    kick(1'b1, 12'd5);
    stream(-1, 0, -1);
    check_val("same_edge_r1", 32'(cap_d[0][0]), 5);

    // Two back-to-back runs with a non-trivial matrix and no reload.
    for (int k = 0; k < 16; k++) load(1'b0, k, DATA_WIDTH'(100 + 3*k));
    for (int k = 0; k < 16; k++) load(1'b1, k, DATA_WIDTH'(4000 - 7*k));
    kick(1'b0, '0);
    stream(-1, 0, -1);
    kick(1'b0, '0);
    stream(5, 1, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

`default_nettype wire
